// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment reader: active-low segment
// codes in {g,f,e,d,c,b,a} order, the blank pattern and the handshake state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        ST_TRACK = 1'b0,
        ST_PEND  = 1'b1
    } state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment-pattern lookup: value, legal and blank flags.
// Hex letters A..F decode to 10..15 only when SEG7_READER_HEX_EN is defined.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] value_o,
    output logic       legal_o,
    output logic       blank_o
);

    always_comb begin
        value_o = 4'd0;
        legal_o = 1'b1;
        blank_o = 1'b0;
        case (pattern_i)
            SEG_0:     value_o = 4'd0;
            SEG_1:     value_o = 4'd1;
            SEG_2:     value_o = 4'd2;
            SEG_3:     value_o = 4'd3;
            SEG_4:     value_o = 4'd4;
            SEG_5:     value_o = 4'd5;
            SEG_6:     value_o = 4'd6;
            SEG_7:     value_o = 4'd7;
            SEG_8:     value_o = 4'd8;
            SEG_9:     value_o = 4'd9;
`ifdef SEG7_READER_HEX_EN
            SEG_HEX_A: value_o = 4'd10;
            SEG_HEX_B: value_o = 4'd11;
            SEG_HEX_C: value_o = 4'd12;
            SEG_HEX_D: value_o = 4'd13;
            SEG_HEX_E: value_o = 4'd14;
            SEG_HEX_F: value_o = 4'd15;
`endif
            SEG_BLANK: begin
                legal_o = 1'b0;
                blank_o = 1'b1;
            end
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_reader.sv
// Debounced seven-segment display reader with a valid/ready digit output and an
// illegal-pattern error counter. Optional hex digits via SEG7_READER_HEX_EN.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [6:0] iSeg,
    input  logic       iReady,
    output logic [3:0] oData,
    output logic       oValid,
    output logic       oErr,
    output logic [7:0] oErrCnt,
    output state_e     oState
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    // Handshake: oValid stays high with oData frozen until a rising edge sees
    // iReady=1; that edge completes the transfer. iReady while !oValid is ignored.

    logic [6:0] seg_q;
    logic [7:0] cnt_q, cnt_d;
    logic       qual_q, qual_d;
    state_e     state_q, state_d;
    logic [3:0] data_q, data_d;
    logic [6:0] last_q, last_d;
    logic       err_q, err_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [3:0] dec_value;
    logic       dec_legal;
    logic       dec_blank;
    logic       stable;

    seg7_decode u_decode (
        .pattern_i (seg_q),
        .value_o   (dec_value),
        .legal_o   (dec_legal),
        .blank_o   (dec_blank)
    );

    // A count of zero means no sample since reset, so the first one always restarts at 1.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == 8'd0 || iSeg != seg_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q != STABLE_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
        qual_d = (cnt_d == STABLE_MAX) && (cnt_q != STABLE_MAX);
    end

    assign stable = (cnt_q == STABLE_MAX);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        last_d    = last_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (stable && dec_blank) begin
            last_d = SEG_BLANK;
        end

        // Errors use the one-cycle qualification pulse so a held bad pattern counts once.
        if (qual_q && !dec_legal && !dec_blank) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        case (state_q)
            ST_TRACK: begin
                if (stable && dec_legal && seg_q != last_q) begin
                    state_d = ST_PEND;
                    data_d  = dec_value;
                    last_d  = seg_q;
                end
            end
            ST_PEND: begin
                if (iReady) begin
                    state_d = ST_TRACK;
                end
            end
            default: state_d = ST_TRACK;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            seg_q     <= SEG_BLANK;
            cnt_q     <= 8'd0;
            qual_q    <= 1'b0;
            state_q   <= ST_TRACK;
            data_q    <= 4'd0;
            last_q    <= SEG_BLANK;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            seg_q     <= iSeg;
            cnt_q     <= cnt_d;
            qual_q    <= qual_d;
            state_q   <= state_d;
            data_q    <= data_d;
            last_q    <= last_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign oData   = data_q;
    assign oValid  = (state_q == ST_PEND);
    assign oErr    = err_q;
    assign oErrCnt = err_cnt_q;
    assign oState  = state_q;

endmodule
